// File: rtl/oldland_mem_arbiter_pkg.sv
// Shared encodings for the oldland memory arbiter: access widths, arbiter
// states and grant identities.
package oldland_mem_arbiter_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_BUS_I = 2'b01,
    ARB_BUS_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_INSN = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  // The external bus is word addressed; byte offsets travel as lane selects.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/oldland_mem_arbiter_if.sv
// Fetch port, data port and external bus signals of the memory arbiter.
// master is the arbiter's view, slave is the view of the surrounding core/bus.
interface oldland_mem_arbiter_if;
  logic        i_access;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_data;
  logic        i_error;
  logic        d_access;
  logic [31:0] d_addr;
  logic        d_wr_en;
  logic [1:0]  d_width;
  logic [31:0] d_wr_val;
  logic        d_ack;
  logic [31:0] d_data;
  logic        d_error;
  logic        bus_access;
  logic [31:0] bus_addr;
  logic        bus_wr_en;
  logic [3:0]  bus_bytesel;
  logic [31:0] bus_wr_val;
  logic [31:0] bus_data;
  logic        bus_ack;
  logic        bus_error;

  modport master (
    input  i_access, i_addr, d_access, d_addr, d_wr_en, d_width, d_wr_val,
           bus_data, bus_ack, bus_error,
    output i_ack, i_data, i_error, d_ack, d_data, d_error,
           bus_access, bus_addr, bus_wr_en, bus_bytesel, bus_wr_val
  );

  modport slave (
    output i_access, i_addr, d_access, d_addr, d_wr_en, d_width, d_wr_val,
           bus_data, bus_ack, bus_error,
    input  i_ack, i_data, i_error, d_ack, d_data, d_error,
           bus_access, bus_addr, bus_wr_en, bus_bytesel, bus_wr_val
  );
endinterface

// File: rtl/oldland_mem_arbiter_byte_lane.sv
// Byte-lane steering for sub-word data accesses: lane selects and store
// replication for the request, right-alignment and zero-extension for loads.
module oldland_byte_lane
  import oldland_mem_arbiter_pkg::*;
(
  input  logic [1:0]  req_width,
  input  logic [1:0]  req_offset,
  input  logic [31:0] wr_val,
  input  logic [1:0]  rsp_width,
  input  logic [1:0]  rsp_offset,
  input  logic [31:0] rd_raw,
  output logic [3:0]  bytesel,
  output logic [31:0] wr_rep,
  output logic [31:0] rd_aligned
);

  // Request side: active lanes and store data copied onto every lane.
  always_comb begin
    bytesel = 4'b1111;
    wr_rep  = wr_val;
    case (req_width)
      MEM_WIDTH_BYTE: begin
        bytesel = 4'b0001 << req_offset;
        wr_rep  = {4{wr_val[7:0]}};
      end
      MEM_WIDTH_HALF: begin
        bytesel = 4'b0011 << {req_offset[1], 1'b0};
        wr_rep  = {2{wr_val[15:0]}};
      end
      default: begin
        bytesel = 4'b1111;
        wr_rep  = wr_val;
      end
    endcase
  end

  // Response side: move the addressed lanes down to bit 0, clear the rest.
  always_comb begin
    rd_aligned = rd_raw;
    case (rsp_width)
      MEM_WIDTH_BYTE: rd_aligned = (rd_raw >> {rsp_offset, 3'b000}) & 32'h0000_00FF;
      MEM_WIDTH_HALF: rd_aligned = (rd_raw >> {rsp_offset[1], 4'b0000}) & 32'h0000_FFFF;
      default:        rd_aligned = rd_raw;
    endcase
  end

endmodule

// File: rtl/oldland_mem_arbiter.sv
// Round-robin arbiter sharing one external memory bus between instruction
// fetch and data access, with bus timeout reported as an error completion.
module oldland_mem_arbiter
  import oldland_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  oldland_mem_arbiter_if.master  mif
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  d_width_q, d_width_d;
  logic [1:0]  d_off_q, d_off_d;
  logic        bus_access_q, bus_access_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_wr_en_q, bus_wr_en_d;
  logic [3:0]  bus_bytesel_q, bus_bytesel_d;
  logic [31:0] bus_wr_val_q, bus_wr_val_d;
  logic        i_ack_q, i_ack_d;
  logic [31:0] i_data_q, i_data_d;
  logic        i_error_q, i_error_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_error_q, d_error_d;

  logic        elig_i_s, elig_d_s;
  logic [3:0]  lane_sel_s;
  logic [31:0] lane_wr_s, lane_rd_s;

  oldland_byte_lane u_byte_lane (
    .req_width  (mif.d_width),
    .req_offset (mif.d_addr[1:0]),
    .wr_val     (mif.d_wr_val),
    .rsp_width  (d_width_q),
    .rsp_offset (d_off_q),
    .rd_raw     (mif.bus_data),
    .bytesel    (lane_sel_s),
    .wr_rep     (lane_wr_s),
    .rd_aligned (lane_rd_s)
  );

  // A request still held high in its own ack cycle is already served.
  assign elig_i_s = mif.i_access & ~i_ack_q;
  assign elig_d_s = mif.d_access & ~d_ack_q;

  // Next-state and next-output computation for the arbiter.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    d_width_d     = d_width_q;
    d_off_d       = d_off_q;
    bus_access_d  = bus_access_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_en_d   = bus_wr_en_q;
    bus_bytesel_d = bus_bytesel_q;
    bus_wr_val_d  = bus_wr_val_q;
    i_ack_d       = 1'b0;
    i_data_d      = i_data_q;
    i_error_d     = i_error_q;
    d_ack_d       = 1'b0;
    d_data_d      = d_data_q;
    d_error_d     = d_error_q;
    case (state_q)
      ARB_IDLE: begin
        if (elig_i_s && (!elig_d_s || (last_grant_q == GRANT_DATA))) begin
          state_d       = ARB_BUS_I;
          last_grant_d  = GRANT_INSN;
          cnt_d         = 8'd0;
          bus_access_d  = 1'b1;
          bus_addr_d    = word_addr(mif.i_addr);
          bus_wr_en_d   = 1'b0;
          bus_bytesel_d = 4'b1111;
          bus_wr_val_d  = 32'd0;
        end else if (elig_d_s) begin
          state_d       = ARB_BUS_D;
          last_grant_d  = GRANT_DATA;
          cnt_d         = 8'd0;
          d_width_d     = mif.d_width;
          d_off_d       = mif.d_addr[1:0];
          bus_access_d  = 1'b1;
          bus_addr_d    = word_addr(mif.d_addr);
          bus_wr_en_d   = mif.d_wr_en;
          bus_bytesel_d = lane_sel_s;
          bus_wr_val_d  = lane_wr_s;
        end else begin
          bus_access_d  = 1'b0;
        end
      end
      ARB_BUS_I, ARB_BUS_D: begin
        // A slave ack on the final timeout cycle still counts as a normal completion.
        if (mif.bus_ack || (cnt_q == TMO_LAST)) begin
          state_d      = ARB_IDLE;
          bus_access_d = 1'b0;
          bus_wr_en_d  = 1'b0;
          if (state_q == ARB_BUS_I) begin
            i_ack_d   = 1'b1;
            i_data_d  = mif.bus_ack ? mif.bus_data : 32'd0;
            i_error_d = mif.bus_ack ? mif.bus_error : 1'b1;
          end else begin
            d_ack_d   = 1'b1;
            d_data_d  = mif.bus_ack ? lane_rd_s : 32'd0;
            d_error_d = mif.bus_ack ? mif.bus_error : 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d      = ARB_IDLE;
        bus_access_d = 1'b0;
        bus_wr_en_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= GRANT_INSN;
      cnt_q         <= 8'd0;
      d_width_q     <= 2'b00;
      d_off_q       <= 2'b00;
      bus_access_q  <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_wr_en_q   <= 1'b0;
      bus_bytesel_q <= 4'd0;
      bus_wr_val_q  <= 32'd0;
      i_ack_q       <= 1'b0;
      i_data_q      <= 32'd0;
      i_error_q     <= 1'b0;
      d_ack_q       <= 1'b0;
      d_data_q      <= 32'd0;
      d_error_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      d_width_q     <= d_width_d;
      d_off_q       <= d_off_d;
      bus_access_q  <= bus_access_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_en_q   <= bus_wr_en_d;
      bus_bytesel_q <= bus_bytesel_d;
      bus_wr_val_q  <= bus_wr_val_d;
      i_ack_q       <= i_ack_d;
      i_data_q      <= i_data_d;
      i_error_q     <= i_error_d;
      d_ack_q       <= d_ack_d;
      d_data_q      <= d_data_d;
      d_error_q     <= d_error_d;
    end
  end

  assign mif.bus_access  = bus_access_q;
  assign mif.bus_addr    = bus_addr_q;
  assign mif.bus_wr_en   = bus_wr_en_q;
  assign mif.bus_bytesel = bus_bytesel_q;
  assign mif.bus_wr_val  = bus_wr_val_q;
  assign mif.i_ack       = i_ack_q;
  assign mif.i_data      = i_data_q;
  assign mif.i_error     = i_error_q;
  assign mif.d_ack       = d_ack_q;
  assign mif.d_data      = d_data_q;
  assign mif.d_error     = d_error_q;

endmodule
